// File: rtl/pwconv_sched_if.sv
// Handshake bundle between the pointwise-conv scheduler, the tile source, the weight ROM
// and the PWConv + rescale pipeline.
interface pwconv_sched_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic              start_i;
  logic              out_ready_i;
  logic              res_valid_i;
  logic              wgt_rd_o;
  logic [ADDR_W-1:0] wgt_addr_o;
  logic              calc_en_o;
  logic [ADDR_W-1:0] ch_idx_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  // Scheduler side
  modport master (
    input  start_i, out_ready_i, res_valid_i,
    output wgt_rd_o, wgt_addr_o, calc_en_o, ch_idx_o, busy_o, done_o, err_o
  );

  // Environment side
  modport slave (
    output start_i, out_ready_i, res_valid_i,
    input  wgt_rd_o, wgt_addr_o, calc_en_o, ch_idx_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/pwconv_sched.sv
// Per-tile channel sequencer for the 3rd-layer pointwise conv: ROM fetch, calc enable,
// wait for the datapath result, repeat for every output channel.
module pwconv_sched #(
  parameter int unsigned OUT_CH  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ROM_LAT = 2
) (
  input logic            clk,
  input logic            rst_n,
  pwconv_sched_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRom,
    StIssue,
    StWaitRes,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] LastCh = ADDR_W'(OUT_CH - 1);
  localparam logic [3:0]        RomLat = 4'(ROM_LAT);

  state_e            state_q;
  logic [ADDR_W-1:0] ch_q;
  logic [3:0]        lat_q;
  logic              calc_en_q;
  logic              done_q;
  logic              err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      lat_q     <= '0;
      calc_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      calc_en_q <= 1'b0;
      done_q    <= 1'b0;
      // Stray strobes are ignored by the FSM but remembered until reset.
      if ((bus.start_i && state_q != StIdle) || (bus.res_valid_i && state_q != StWaitRes)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            state_q <= StFetch;
            ch_q    <= '0;
          end
        end
        StFetch: begin
          if (bus.out_ready_i) begin
            lat_q   <= RomLat;
            state_q <= StWaitRom;
          end
        end
        StWaitRom: begin
          lat_q <= lat_q - 4'd1;
          if (lat_q == 4'd1) begin
            state_q   <= StIssue;
            calc_en_q <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWaitRes;
        end
        StWaitRes: begin
          if (bus.res_valid_i) begin
            if (ch_q == LastCh) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              ch_q    <= ch_q + ADDR_W'(1);
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          ch_q    <= '0;
        end
        default: begin
          state_q <= StIdle;
          ch_q    <= '0;
        end
      endcase
    end
  end

  // The read strobe follows out_ready_i combinationally so the fetch costs no extra cycle.
  assign bus.wgt_rd_o   = (state_q == StFetch) && bus.out_ready_i;
  assign bus.wgt_addr_o = ch_q;
  assign bus.ch_idx_o   = ch_q;
  assign bus.calc_en_o  = calc_en_q;
  assign bus.busy_o     = (state_q != StIdle);
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

endmodule
